unidade_load_store: RTL

- Load/store unit between the execute stage and the data memory (64-bit words, 32 entries, whole-word write, combinational read).
- Accepts one byte-addressed RISC-V load or store per handshake.
- Maps the byte address onto the word-indexed memory and performs sub-word stores by read-modify-write.
- Returns sign- or zero-extended load data plus an error flag for misaligned, out-of-range or illegal accesses.

---
 rtl/unidade_load_store.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/unidade_load_store.sv
// Load/store unit between execute and a word-indexed data memory.
// Handles RISC-V B/H/W/D loads and stores; sub-word stores use read-modify-write.
module unidade_load_store #(
    parameter int unsigned BITS   = 64,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [BITS-1:0]   req_addr,
    input  logic [BITS-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [BITS-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_We,
    output logic [BITS-1:0]   mem_din,
    input  logic [BITS-1:0]   mem_dout
);

    localparam int unsigned NBYTES = BITS / 8;
    localparam int unsigned OFF_W  = $clog2(NBYTES);
    localparam int unsigned LO     = ADDR_W + OFF_W;
    localparam int unsigned SH_W   = OFF_W + 3;

    typedef enum logic [1:0] {IDLE, EXEC, WRITE, RESP} state_t;

    state_t              r_state, w_next;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [BITS-1:0]     r_addr;
    logic [BITS-1:0]     r_wdata;

    logic                w_ready_n, w_valid_n, w_err_n, w_we_n;
    logic [BITS-1:0]     w_rdata_n, w_din_n;
    logic [ADDR_W-1:0]   w_addr_n;

    logic [OFF_W-1:0]    w_off;
    logic [ADDR_W-1:0]   w_index;
    logic [SH_W-1:0]     w_shamt;
    logic                w_misalign, w_illegal, w_range, w_err;
    logic [BITS-1:0]     w_shifted, w_load, w_mask, w_merged;
    logic [NBYTES-1:0]   w_base, w_bmask;

    assign w_off   = r_addr[OFF_W-1:0];
    assign w_index = r_addr[LO-1:OFF_W];
    assign w_shamt = {w_off, 3'b000};

    // Access checks on the latched request
    always_comb begin
        w_misalign = 1'b0;
        case (r_funct3[1:0])
            2'b01:   w_misalign = w_off[0];
            2'b10:   w_misalign = |w_off[1:0];
            2'b11:   w_misalign = |w_off;
            default: w_misalign = 1'b0;
        endcase
        w_illegal = (r_funct3 == 3'b111) | (r_funct3[2] & r_we);
        w_range   = (|r_addr[BITS-1:LO]) |
                    ((ADDR_W+1)'(w_index) >= (ADDR_W+1)'(DEPTH));
        w_err     = w_misalign | w_illegal | w_range;
    end

    // Load extraction with sign/zero extension
    always_comb begin
        w_shifted = mem_dout >> w_shamt;
        case (r_funct3)
            3'b000:  w_load = BITS'($signed(w_shifted[7:0]));
            3'b001:  w_load = BITS'($signed(w_shifted[15:0]));
            3'b010:  w_load = BITS'($signed(w_shifted[31:0]));
            3'b011:  w_load = w_shifted;
            3'b100:  w_load = BITS'(w_shifted[7:0]);
            3'b101:  w_load = BITS'(w_shifted[15:0]);
            3'b110:  w_load = BITS'(w_shifted[31:0]);
            default: w_load = '0;
        endcase
    end

    // Store merge: byte mask expanded to bits, new data overlaid on the old word
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_base = NBYTES'(1);
            2'b01:   w_base = NBYTES'(3);
            2'b10:   w_base = NBYTES'(15);
            default: w_base = NBYTES'(255);
        endcase
        w_bmask = w_base << w_off;
        w_mask  = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            w_mask[8*i +: 8] = {8{w_bmask[i]}};
        end
        w_merged = (mem_dout & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_ready_n = 1'b0;
        w_valid_n = 1'b0;
        w_err_n   = resp_err;
        w_rdata_n = resp_rdata;
        w_we_n    = 1'b0;
        w_din_n   = '0;
        w_addr_n  = mem_addr;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next   = EXEC;
                    w_addr_n = req_addr[LO-1:OFF_W];
                end else begin
                    w_ready_n = 1'b1;
                end
            end
            EXEC: begin
                if (w_err) begin
                    w_next    = RESP;
                    w_valid_n = 1'b1;
                    w_err_n   = 1'b1;
                    w_rdata_n = '0;
                end else if (r_we) begin
                    w_next  = WRITE;
                    w_we_n  = 1'b1;
                    w_din_n = w_merged;
                end else begin
                    w_next    = RESP;
                    w_valid_n = 1'b1;
                    w_err_n   = 1'b0;
                    w_rdata_n = w_load;
                end
            end
            WRITE: begin
                w_next    = RESP;
                w_valid_n = 1'b1;
                w_err_n   = 1'b0;
                w_rdata_n = '0;
            end
            RESP: begin
                w_next    = IDLE;
                w_ready_n = 1'b1;
            end
            default: begin
                w_next    = IDLE;
                w_ready_n = 1'b1;
            end
        endcase
    end

    // Registered outputs; mem_din doubles as the write buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_We     <= 1'b0;
            mem_din    <= '0;
            mem_addr   <= '0;
        end else begin
            req_ready  <= w_ready_n;
            resp_valid <= w_valid_n;
            resp_rdata <= w_rdata_n;
            resp_err   <= w_err_n;
            mem_We     <= w_we_n;
            mem_din    <= w_din_n;
            mem_addr   <= w_addr_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (r_state == IDLE && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

endmodule
